// File: rtl/uart_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_loader
//  Description : Boot-time program loader. Parses a length-prefixed byte
//                stream from the UART receiver, assembles little-endian 32-bit
//                words, writes them to instruction memory from address 0,
//                returns a one-byte acknowledge and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_loader #(
   parameter int          ADDR_W  = 14,
   parameter logic [7:0]  ACK_OK  = 8'hAA,
   parameter logic [7:0]  ACK_ERR = 8'hEE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] c_IDLE = 3'd0;
   localparam logic [2:0] c_HDR  = 3'd1;
   localparam logic [2:0] c_BODY = 3'd2;
   localparam logic [2:0] c_ACK  = 3'd3;
   localparam logic [2:0] c_FIN  = 3'd4;

   // Largest legal image in words; one extra bit so 2^ADDR_W is representable.
   localparam logic [32:0] c_MAX_WORDS = 33'd1 << ADDR_W;

   logic [2:0]        state_q,     state_d;
   logic [1:0]        byte_cnt_q,  byte_cnt_d;
   logic [31:0]       shift_q,     shift_d;
   logic [31:0]       count_q,     count_d;
   logic [31:0]       word_cnt_q,  word_cnt_d;
   logic              mem_we_q,    mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [7:0]        tx_data_q,   tx_data_d;
   logic              tx_valid_q,  tx_valid_d;
   logic              busy_q,      busy_d;
   logic              done_q,      done_d;
   logic              err_q,       err_d;

   // Bytes arrive LSB first, so shifting each new byte in at the top leaves
   // the complete little-endian word in place once the 4th byte arrives.
   logic [31:0] w_word;
   logic        w_group_end;
   logic        w_last_word;

   assign w_word      = {rx_data, shift_q[31:8]};
   assign w_group_end = (byte_cnt_q == 2'd3);
   // Full 32-bit compare, so an image of exactly 2^ADDR_W words terminates
   // even though the address itself wraps.
   assign w_last_word = ((word_cnt_q + 32'd1) == count_q);

   // Next-state logic for the loader sequence and all registered outputs.
   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      shift_d     = shift_q;
      count_d     = count_q;
      word_cnt_d  = word_cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         c_IDLE: begin
            if (start) begin
               state_d    = c_HDR;
               busy_d     = 1'b1;
               err_d      = 1'b0;
               byte_cnt_d = 2'd0;
               word_cnt_d = 32'd0;
               shift_d    = 32'd0;
            end
         end

         c_HDR: begin
            if (rx_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = w_word;
               if (w_group_end) begin
                  count_d = w_word;
                  if (w_word == 32'd0) begin
                     state_d    = c_ACK;
                     tx_valid_d = 1'b1;
                     tx_data_d  = ACK_OK;
                  end else if ({1'b0, w_word} > c_MAX_WORDS) begin
                     state_d    = c_ACK;
                     tx_valid_d = 1'b1;
                     tx_data_d  = ACK_ERR;
                     err_d      = 1'b1;
                  end else begin
                     state_d = c_BODY;
                  end
               end
            end
         end

         c_BODY: begin
            if (rx_valid) begin
               byte_cnt_d = byte_cnt_q + 2'd1;
               shift_d    = w_word;
               if (w_group_end) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = word_cnt_q[ADDR_W-1:0];
                  mem_wdata_d = w_word;
                  word_cnt_d  = word_cnt_q + 32'd1;
                  if (w_last_word) begin
                     state_d = c_ACK;
                  end
               end
            end
         end

         c_ACK: begin
            // Entered from BODY with tx_valid low: raise it one cycle after
            // the final write. Header-terminated loads arrive already valid.
            if (!tx_valid_q) begin
               tx_valid_d = 1'b1;
               tx_data_d  = err_q ? ACK_ERR : ACK_OK;
            end else if (tx_ready) begin
               tx_valid_d = 1'b0;
               done_d     = 1'b1;
               busy_d     = 1'b0;
               state_d    = c_FIN;
            end
         end

         c_FIN: begin
            state_d = c_IDLE;
         end

         default: begin
            state_d = c_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= c_IDLE;
         byte_cnt_q  <= 2'd0;
         shift_q     <= 32'd0;
         count_q     <= 32'd0;
         word_cnt_q  <= 32'd0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'd0;
         tx_data_q   <= 8'd0;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_cnt_q  <= byte_cnt_d;
         shift_q     <= shift_d;
         count_q     <= count_d;
         word_cnt_q  <= word_cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         tx_data_q   <= tx_data_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign tx_data   = tx_data_q;
   assign tx_valid  = tx_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule
`default_nettype wire
